mem_rmw_ctrl: RTL and testbench
===============================

MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 Parameter: ADDR_BITS, 16, byte-address width backed by the 16Kx32 SRAM; addresses with nonzero bits above it are out of range.
REQ-002 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  1  request valid.
REQ-006 req_ready_o  out  1  controller can accept a request.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned_i  in  1  load zero-extend when 1, sign-extend when 0.
REQ-010 req_addr_i  in  32  byte address.
REQ-011 req_wdata_i  in  32  store data, right-aligned.
REQ-012 rsp_valid_o  out  1  response valid.
REQ-013 rsp_ready_i  in  1  response consumed.
REQ-014 rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-015 rsp_err_o  out  1  misaligned, illegal-size or out-of-range request.
REQ-016 mem_en_o, mem_wen_o  out  1 each  SRAM enable and whole-word write enable.
REQ-017 mem_addr_o  out  32  SRAM byte address, always {addr[31:2],2'b00}.
REQ-018 mem_wdata_o  out  32  SRAM write word.
REQ-019 mem_rdata_i  in  32  SRAM read word, valid the cycle after a read enable.

Function
REQ-020 States: IDLE, READ, MERGE, WRITE, RESP; only one request is in flight at a time.
REQ-021 req_ready_o is 1 only in IDLE; a request is accepted on the edge where req_valid_i and req_ready_o are both 1, and all request fields are latched at that edge.
REQ-022 Errors: half with addr[0]=1, word with addr[1:0]!=0, size 11, or addr[31:ADDR_BITS]!=0 go IDLE->RESP with rsp_err_o=1 and no SRAM access.
REQ-023 Load: IDLE->READ (en=1, wen=0)->MERGE (capture mem_rdata_i)->RESP; rsp_valid_o is high 3 cycles after acceptance.
REQ-024 Word store: IDLE->WRITE (en=1, wen=1, wdata=req_wdata)->RESP; rsp_valid_o is high 2 cycles after acceptance.
REQ-025 Sub-word store: IDLE->READ->MERGE (replace selected lane(s) of the read word)->WRITE->RESP; rsp_valid_o is high 4 cycles after acceptance.
REQ-026 Lane select: byte lane = addr[1:0] (lane 0 = bits 7:0); half lane = addr[1].
REQ-027 Load result: the selected lane is right-aligned, then sign- or zero-extended to 32 bits per req_unsigned_i; words are passed unchanged.
REQ-028 mem_en_o = 1 only in READ or WRITE; mem_wen_o = 1 only in WRITE; mem_wdata_o = 0 outside WRITE.
REQ-029 RESP holds rsp_valid_o and the response data stable until rsp_ready_i=1, then returns to IDLE; a new request is accepted no earlier than the following cycle.
REQ-030 rsp_valid_o is 0 outside RESP; rsp_err_o and rsp_rdata_o are 0 when rsp_valid_o is 0.

Reset
REQ-031 While rst_i=1: state=IDLE, and all latched request and data registers = 0.
REQ-032 Reset outputs: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_en_o=0, mem_wen_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-033 Reset mid-operation aborts the request with no response; a sub-word store reset before WRITE never writes the SRAM.

Structure
REQ-034 Package mem_pkg holds the size encodings (SZ_B, SZ_H, SZ_W), the state enumeration and the lane-index helper constants.
REQ-035 Sub-module mem_lane_align: purely combinational load extract/extend and store merge, instantiated once.
REQ-036 The block connects directly to sram16kx32 (1-cycle read latency, single write enable).

Verification
REQ-037 Word store 0xDEADBEEF @0x10, then word load @0x10 -> WRITE 1 cycle after acceptance, rsp_rdata_o=0xDEADBEEF 3 cycles after acceptance, err=0.
REQ-038 Word 0x11223344 @0x20; store byte 0xAA @0x21; word load -> exactly one read and one write are seen on the SRAM port; result 0x1122AA44.
REQ-039 Word 0x80FF7F01 @0x30; loads: signed byte @0x31 -> 0x0000007F; signed byte @0x32 -> 0xFFFFFFFF; unsigned half @0x32 -> 0x000080FF; signed half @0x32 -> 0xFFFF80FF.
REQ-040 Half load @0x03, word store @0x06, size 11, load @0x00010000 -> rsp_err_o=1 one cycle after acceptance, mem_en_o never asserted.
REQ-041 rsp_ready_i held 0 for 5 cycles during RESP -> response stable and req_ready_o=0 throughout; a reset pulse during MERGE of a byte store -> no SRAM write, outputs at reset values the next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory read-modify-write controller:
// access sizes, controller states and lane-index helpers.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam int LANE_BITS  = 8;
  localparam int LANE_IDX_W = 2;

  // Bit offset of a byte lane inside a 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [LANE_IDX_W-1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extract plus sign/zero extension,
// and store merge of a byte or half into a read word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  sh_s;
  logic [15:0] lane_s;
  logic [31:0] mask_s;
  logic        sext_s;

  // Half accesses are always aligned, so lane_i[0] is 0 for them.
  always_comb begin
    sh_s   = lane_shift(lane_i);
    lane_s = 16'(rword_i >> sh_s);
    sext_s = (unsigned_i == 1'b0);
    load_o = rword_i;
    mask_s = 32'hFFFF_FFFF;
    case (size_i)
      SZ_B: begin
        mask_s = 32'h0000_00FF << sh_s;
        load_o = {{24{sext_s & lane_s[7]}}, lane_s[7:0]};
      end
      SZ_H: begin
        mask_s = 32'h0000_FFFF << sh_s;
        load_o = {{16{sext_s & lane_s[15]}}, lane_s};
      end
      default: begin
        mask_s = 32'hFFFF_FFFF;
        load_o = rword_i;
      end
    endcase
    merge_o = (rword_i & ~mask_s) | ((wdata_i << sh_s) & mask_s);
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Single-outstanding load/store controller for a 1-cycle-latency 16Kx32 SRAM;
// sub-word stores are done as read-merge-write of the containing word.
module mem_rmw_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_en_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        err_q, err_d;

  logic        req_err_s;
  logic        misalign_s;
  logic [31:0] load_s;
  logic [31:0] merge_s;

  // Request legality check on the live request fields.
  always_comb begin
    misalign_s = 1'b0;
    case (req_size_i)
      SZ_B:    misalign_s = 1'b0;
      SZ_H:    misalign_s = req_addr_i[0];
      SZ_W:    misalign_s = |req_addr_i[1:0];
      default: misalign_s = 1'b1;
    endcase
    req_err_s = misalign_s | ((req_addr_i >> ADDR_BITS) != 32'd0);
  end

  mem_lane_align u_lane_align (
    .rword_i    (mem_rdata_i),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_s),
    .merge_o    (merge_s)
  );

  // Next-state and latched-request update.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d       = req_we_i;
          size_d     = req_size_i;
          uns_d      = req_unsigned_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          rsp_data_d = 32'd0;
          err_d      = req_err_s;
          if (req_err_s) begin
            state_d = ST_RESP;
          end else if (req_we_i && (req_size_i == SZ_W)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: begin
        if (we_q) begin
          wdata_d = merge_s;
          state_d = ST_WRITE;
        end else begin
          rsp_data_d = load_s;
          state_d    = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rsp_data_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = (state_q == ST_RESP) ? err_q : 1'b0;
  assign rsp_rdata_o = (state_q == ST_RESP) ? rsp_data_q : 32'd0;
  assign mem_en_o    = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign mem_wen_o   = (state_q == ST_WRITE);
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = (state_q == ST_WRITE) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: SRAM model, directed scenarios and
// randomized requests checked against an arithmetic reference memory.
module tb_mem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_en_o, mem_wen_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_rmw_ctrl #(.ADDR_BITS(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_en_o       (mem_en_o),
    .mem_wen_o      (mem_wen_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata)
  );

  bit [31:0] sram    [0:16383];
  bit [31:0] ref_mem [0:16383];
  int n_chk = 0, n_fail = 0;
  int n_rd = 0, n_wr = 0, n_en = 0, n_bad = 0;
  int cyc = 0, wr_cyc = 0, acc_cyc = 0;

  // SRAM model plus protocol monitor on every rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en_o) begin
      n_en <= n_en + 1;
      if (mem_wen_o) begin
        sram[mem_addr_o[15:2]] <= mem_wdata_o;
        n_wr   <= n_wr + 1;
        wr_cyc <= cyc + 1;
      end else begin
        mem_rdata <= sram[mem_addr_o[15:2]];
        n_rd      <= n_rd + 1;
      end
    end
    if ((!mem_wen_o && mem_wdata_o != 32'd0) || (mem_wen_o && !mem_en_o) ||
        (mem_addr_o[1:0] != 2'b00) ||
        (!rsp_valid_o && (rsp_err_o || rsp_rdata_o != 32'd0)) ||
        (rsp_valid_o && req_ready_o))
      n_bad <= n_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: expected data, error and latency; commits stores.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] d, output logic e, output int lat);
    longint unsigned w, v, nb, sh;
    int unsigned idx;
    idx = (addr / 4) % 16384;
    sh  = 8 * (addr % 4);
    nb  = (sz == 2'd0) ? 256 : 65536;
    e = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0) ||
        (addr >= 32'd65536);
    d = 32'd0;
    w = ref_mem[idx];
    if (e) begin
      lat = 1;
    end else if (!we) begin
      lat = 3;
      if (sz == 2'd2) d = w[31:0];
      else begin
        v = (w >> sh) % nb;
        if (!uns && v >= nb / 2) v = v + 64'h1_0000_0000 - nb;
        d = v[31:0];
      end
    end else if (sz == 2'd2) begin
      lat = 2;
      ref_mem[idx] = wd;
    end else begin
      lat = 4;
      v = (w >> sh) % nb;
      w = w - (v << sh) + ((longint'(wd) % nb) << sh);
      ref_mem[idx] = w[31:0];
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        input string tag);
    logic [31:0] ed, held;
    logic        ee;
    int          el, lat, guard;
    model(we, sz, uns, addr, wd, ed, ee, el);
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check({tag, " ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " err"}, 32'(rsp_err_o), 32'(ee));
    check({tag, " rdata"}, rsp_rdata_o, ed);
    held = rsp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(rsp_valid_o), 32'd1);
      check({tag, " hold rdata"}, rsp_rdata_o, held);
      check({tag, " hold ready"}, 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    check({tag, " done"}, {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
  endtask

  initial begin
    int rd0, wr0, en0;
    logic [1:0]  sz;
    logic [31:0] a;
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
    req_unsigned_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(req_ready_o), 32'd1);
    check("reset rsp", {29'd0, rsp_valid_o, rsp_err_o, |rsp_rdata_o}, 32'd0);
    check("reset mem ctl", {30'd0, mem_en_o, mem_wen_o}, 32'd0);
    check("reset mem addr", mem_addr_o, 32'd0);
    check("reset mem wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 64; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, "prefill");

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "st w 10");
    check("st w write cycle", 32'(wr_cyc - acc_cyc), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, "ld w 10");

    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, "st w 20");
    rd0 = n_rd; wr0 = n_wr;
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 0, "st b 21");
    check("st b reads", 32'(n_rd - rd0), 32'd1);
    check("st b writes", 32'(n_wr - wr0), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, "ld w 20");
    check("ld w 20 value", ref_mem[8], 32'h1122AA44);

    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F01, 0, "st w 30");
    do_req(1'b0, 2'd0, 1'b0, 32'h31, 32'd0, 0, "ld sb 31");
    do_req(1'b0, 2'd0, 1'b0, 32'h32, 32'd0, 0, "ld sb 32");
    do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'd0, 0, "ld uh 32");
    do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'd0, 0, "ld sh 32");

    en0 = n_en;
    do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'd0, 0, "err half");
    do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h55, 0, "err word");
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, 0, "err size");
    do_req(1'b0, 2'd2, 1'b0, 32'h00010000, 32'd0, 0, "err range");
    check("err no sram", 32'(n_en - en0), 32'd0);

    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 5, "stall ld");

    wr0 = n_wr;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
    req_addr_i = 32'h31; req_wdata_i = 32'h000000CC;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst merge ready", {30'd0, req_ready_o, rsp_valid_o}, 32'd2);
    check("rst merge mem", {30'd0, mem_en_o, mem_wen_o}, 32'd0);
    check("rst merge addr", mem_addr_o, 32'd0);
    check("rst merge wdata", mem_wdata_o, 32'd0);
    @(posedge clk); #1;
    check("rst merge no write", 32'(n_wr - wr0), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 0, "after rst ld");

    for (int i = 0; i < 150; i++) begin
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a  = $urandom % 256;
      if ($urandom % 4 != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz == 2'd2) a[1:0] = 2'b00;
        else a = a;
      end
      if ($urandom % 16 == 0) a = a | (32'h0001_0000 << ($urandom % 16));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom % 3), "rand");
    end

    check("monitor violations", 32'(n_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
